// File: rtl/pixel_sequencer.sv
// rtl/pixel_sequencer.sv - walks an image through BRAM read, process-stage handshake and destination write
`timescale 1ns/1ps
module pixel_sequencer #(
  parameter int NPIX   = 200000,
  parameter int AW     = 18,
  parameter int RD_LAT = 1
) (
  input  logic          clka,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          ena,
  output logic [AW-1:0] addra,
  input  logic [23:0]   douta,
  output logic [7:0]    Rin,
  output logic [7:0]    Gin,
  output logic [7:0]    Bin,
  output logic          OKin,
  input  logic [7:0]    Rout,
  input  logic [7:0]    Gout,
  input  logic [7:0]    Bout,
  input  logic          OKout,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [23:0]   wr_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, PRESENT, WRITE, RELEASE, DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX  = AW'(NPIX - 1);
  localparam logic [1:0]    WAIT_LAST = 2'(RD_LAT - 1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [1:0]    wait_cnt;

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      ena      <= 1'b0;
      addra    <= '0;
      Rin      <= '0;
      Gin      <= '0;
      Bin      <= '0;
      OKin     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort && state != IDLE) begin
      // Cancel drops every handshake and strobe; captured data is left as-is.
      state <= IDLE;
      ena   <= 1'b0;
      OKin  <= 1'b0;
      wr_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            idx   <= '0;
            addra <= '0;
            ena   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        READ: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          // Address stays put for the whole BRAM latency so douta is settled here.
          if (wait_cnt == WAIT_LAST) begin
            state           <= PRESENT;
            ena             <= 1'b0;
            {Rin, Gin, Bin} <= douta;
            OKin            <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        PRESENT: begin
          if (OKout) begin
            state   <= WRITE;
            OKin    <= 1'b0;
            wr_en   <= 1'b1;
            wr_addr <= idx;
            wr_data <= {Rout, Gout, Bout};
          end
        end
        WRITE: begin
          state <= RELEASE;
          wr_en <= 1'b0;
        end
        RELEASE: begin
          // Wait for the process stage to drop its result before the next pixel.
          if (!OKout) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              idx   <= idx + 1'b1;
              addra <= idx + 1'b1;
              ena   <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sequencer.sv
// tb/tb_pixel_sequencer.sv - scoreboard bench for pixel_sequencer at RD_LAT 1 and 3
`timescale 1ns/1ps
module tb_pixel_sequencer;
  localparam int AW   = 18;
  localparam int NPIX = 4;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic          reset;
  logic          start_v [2];
  logic          abort_v [2];
  logic          ena_v [2];
  logic [AW-1:0] addra_v [2];
  logic [23:0]   douta_v [2];
  logic [7:0]    rin_v [2], gin_v [2], bin_v [2];
  logic [7:0]    rout_v [2], gout_v [2], bout_v [2];
  logic          okin_v [2], okout_v [2], wr_en_v [2], busy_v [2], done_v [2];
  logic [AW-1:0] wr_addr_v [2];
  logic [23:0]   wr_data_v [2];

  pixel_sequencer #(.NPIX(NPIX), .AW(AW), .RD_LAT(1)) dut0 (
    .clka(clka), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
    .ena(ena_v[0]), .addra(addra_v[0]), .douta(douta_v[0]),
    .Rin(rin_v[0]), .Gin(gin_v[0]), .Bin(bin_v[0]), .OKin(okin_v[0]),
    .Rout(rout_v[0]), .Gout(gout_v[0]), .Bout(bout_v[0]), .OKout(okout_v[0]),
    .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  pixel_sequencer #(.NPIX(NPIX), .AW(AW), .RD_LAT(3)) dut1 (
    .clka(clka), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
    .ena(ena_v[1]), .addra(addra_v[1]), .douta(douta_v[1]),
    .Rin(rin_v[1]), .Gin(gin_v[1]), .Bin(bin_v[1]), .OKin(okin_v[1]),
    .Rout(rout_v[1]), .Gout(gout_v[1]), .Bout(bout_v[1]), .OKout(okout_v[1]),
    .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  logic [23:0] img [4] = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0};
  logic [23:0] inv [4] = '{24'hEFDFCF, 24'hBFAF9F, 24'h8F7F6F, 24'h5F4F3F};

  // BRAM and process-stage models: OKout rises dly edges after OKin, lingers hold edges after it drops.
  logic [23:0] pipe [2][3];
  int pcnt [2];
  int hc [2];
  int dly  = 1;
  int hold = 0;

  always @(posedge clka) begin
    for (int i = 0; i < 2; i++) begin
      if (ena_v[i]) pipe[i][0] <= img[addra_v[i][1:0]];
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
      rout_v[i]  <= ~rin_v[i];
      gout_v[i]  <= ~gin_v[i];
      bout_v[i]  <= ~bin_v[i];
      if (!reset) begin
        okout_v[i] <= 1'b0;
        pcnt[i]    <= 0;
        hc[i]      <= 0;
      end else if (okin_v[i]) begin
        if (pcnt[i] + 1 >= dly) okout_v[i] <= 1'b1;
        pcnt[i] <= pcnt[i] + 1;
        hc[i]   <= hold;
      end else if (hc[i] > 0) begin
        hc[i]      <= hc[i] - 1;
        okout_v[i] <= 1'b1;
        pcnt[i]    <= 0;
      end else begin
        okout_v[i] <= 1'b0;
        pcnt[i]    <= 0;
      end
    end
  end

  always_comb begin
    douta_v[0] = pipe[0][0];
    douta_v[1] = pipe[1][2];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  typedef struct packed { logic [AW-1:0] a; logic [23:0] d; } wr_t;
  wr_t exp_q [$];

  int sel = 0, cyc = 0, last_wr = -1, exp_period = 6, exp_rd = 0;
  int ena_len = 0, okin_len = 0, wr_seen = 0, done_seen = 0;
  int base_done = 0, base_wr = 0;
  logic p_ena = 1'b0, p_okout = 1'b0, p_okin = 1'b0, moved = 1'b0, changed = 1'b0;
  logic [AW-1:0] p_addra = '0;
  logic [23:0]   p_rgb = '0;

  initial forever begin
    int s;
    wr_t e;
    @(negedge clka);
    s = sel;
    cyc++;
    if (!reset) begin
      p_ena = 1'b0; p_okin = 1'b0; p_okout = 1'b0;
      ena_len = 0; okin_len = 0; moved = 1'b0; changed = 1'b0;
    end else begin
      if (ena_v[s]) begin
        if (!p_ena) begin
          chk("rd_addr", addra_v[s], exp_rd);
          chk("rd_after_okout_low", p_okout, 1'b0);
          exp_rd++;
          ena_len = 1;
        end else begin
          ena_len++;
          if (addra_v[s] != p_addra) moved = 1'b1;
        end
      end else if (p_ena) begin
        chk("ena_cycles", ena_len, (s == 1) ? 4 : 2);
        chk("addra_held", moved, 1'b0);
        moved = 1'b0;
      end
      if (wr_en_v[s]) begin
        chk("present_cycles", okin_len, dly + 1);
        chk("present_stable", changed, 1'b0);
        chk("wr_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr_v[s], e.a);
          chk("wr_data", wr_data_v[s], e.d);
        end
        if (last_wr >= 0) chk("pixel_period", cyc - last_wr, exp_period);
        last_wr = cyc;
        wr_seen++;
        okin_len = 0; changed = 1'b0;
      end else if (!okin_v[s]) begin
        okin_len = 0; changed = 1'b0;
      end
      if (okin_v[s]) begin
        if (p_okin && {rin_v[s], gin_v[s], bin_v[s]} != p_rgb) changed = 1'b1;
        okin_len++;
      end
      if (done_v[s]) begin
        done_seen++;
        chk("busy_at_done", busy_v[s], 1'b1);
      end
      p_ena = ena_v[s]; p_addra = addra_v[s]; p_okout = okout_v[s]; p_okin = okin_v[s];
      p_rgb = {rin_v[s], gin_v[s], bin_v[s]};
    end
  end

  task automatic chk_zero(input int s, input string tag);
    chk({tag, "_ctl"}, {ena_v[s], okin_v[s], wr_en_v[s], busy_v[s], done_v[s], addra_v[s], wr_addr_v[s]}, 64'd0);
    chk({tag, "_dat"}, {rin_v[s], gin_v[s], bin_v[s], wr_data_v[s]}, 64'd0);
  endtask

  task automatic arm(input int s, input int period, input int n);
    sel = s; exp_period = period; last_wr = -1; exp_rd = 0;
    for (int p = 0; p < n; p++) exp_q.push_back({AW'(p), inv[p]});
    base_done = done_seen; base_wr = wr_seen;
  endtask

  task automatic pulse_start(input int s);
    @(negedge clka); #1 start_v[s] = 1'b1;
    @(negedge clka); #1 start_v[s] = 1'b0;
  endtask

  task automatic finish_image(input int s, input bit poke);
    int k;
    bit poked;
    poked = 1'b0;
    for (k = 0; k < 600; k++) begin
      @(negedge clka); #1;
      start_v[s] = 1'b0;
      if (done_seen != base_done) break;
      if (poke && !poked && wr_seen - base_wr == 1) begin
        start_v[s] = 1'b1;
        poked = 1'b1;
      end
    end
    chk("done_within_budget", k < 600, 1'b1);
    @(negedge clka); #1;
    chk("busy_after_done", busy_v[s], 1'b0);
    chk("writes_per_image", wr_seen - base_wr, NPIX);
    chk("queue_drained", exp_q.size(), 0);
    repeat (5) @(negedge clka);
    chk("done_pulses", done_seen - base_done, 1);
  endtask

  initial begin
    int k;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    #7;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");

    // Start already high as reset releases: accepted on the first live edge.
    arm(0, 6, 4);
    start_v[0] = 1'b1;
    @(negedge clka); #2 reset = 1'b1;
    @(posedge clka); #1;
    chk("first_start_busy", busy_v[0], 1'b1);
    @(negedge clka); #1 start_v[0] = 1'b0;
    finish_image(0, 1'b0);

    dly = 5;
    arm(0, 10, 4); pulse_start(0); finish_image(0, 1'b0);

    dly = 1; hold = 2;
    arm(0, 8, 4); pulse_start(0); finish_image(0, 1'b0);
    hold = 0;

    // Abort while pixel 2 is presented.
    arm(0, 6, 2); pulse_start(0);
    for (k = 0; k < 300; k++) begin
      @(negedge clka); #1;
      if (okin_v[0] && wr_seen - base_wr == 2) break;
    end
    chk("abort_reach_pixel2", k < 300, 1'b1);
    abort_v[0] = 1'b1;
    @(negedge clka); #1 abort_v[0] = 1'b0;
    chk("abort_okin", okin_v[0], 1'b0);
    chk("abort_busy", busy_v[0], 1'b0);
    repeat (20) @(negedge clka);
    chk("abort_writes", wr_seen - base_wr, 2);
    chk("abort_no_done", done_seen - base_done, 0);
    arm(0, 6, 4); pulse_start(0); finish_image(0, 1'b0);

    // Asynchronous reset in the WAIT cycle of pixel 1.
    arm(0, 6, 4); pulse_start(0);
    for (k = 0; k < 300; k++) begin
      @(negedge clka); #1;
      if (ena_v[0] && wr_seen - base_wr == 1) break;
    end
    chk("reset_reach_read1", k < 300, 1'b1);
    @(posedge clka); #2 reset = 1'b0;
    #1 chk_zero(0, "async_reset");
    exp_q.delete();
    start_v[0] = 1'b1;
    repeat (2) @(negedge clka);
    chk("start_in_reset", busy_v[0], 1'b0);
    start_v[0] = 1'b0;
    reset = 1'b1;
    repeat (20) @(negedge clka);
    chk("reset_no_writes", wr_seen - base_wr, 1);
    chk("reset_idle", busy_v[0], 1'b0);
    arm(0, 6, 4); pulse_start(0); finish_image(0, 1'b0);

    // RD_LAT=3 instance, with a stray start while busy.
    arm(1, 8, 4); pulse_start(1); finish_image(1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pixel_sequencer.md
PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 Parameter NPIX, default 200000, pixels per image.
REQ-002 Parameter AW, default 18, address width.
REQ-003 Parameter RD_LAT, default 1, source BRAM read latency in cycles (1..3).
REQ-004 clka  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to process a whole image.
REQ-007 abort  in  1  synchronous cancel of a running image.
REQ-008 ena  out  1  source BRAM enable.
REQ-009 addra  out  AW  source BRAM read address.
REQ-010 douta  in  24  source BRAM read data {R,G,B}.
REQ-011 Rin, Gin, Bin  out  8 each  pixel presented to process stage.
REQ-012 OKin  out  1  pixel-valid request to process stage.
REQ-013 Rout, Gout, Bout  in  8 each  processed pixel.
REQ-014 OKout  in  1  process-stage result valid.
REQ-015 wr_en  out  1  destination write strobe.
REQ-016 wr_addr  out  AW  destination address.
REQ-017 wr_data  out  24  destination data {Rout,Gout,Bout}.
REQ-018 busy  out  1  high from start acceptance until DONE exits.
REQ-019 done  out  1  one-cycle pulse after last pixel written.

Function
REQ-020 FSM states: IDLE, READ, WAIT, PRESENT, WRITE, RELEASE, DONE.
REQ-021 IDLE: start=1 -> READ, pixel index idx cleared to 0; start ignored in every other state.
REQ-022 READ (1 cycle): ena=1, addra=idx -> WAIT.
REQ-023 WAIT: ena=1, addra held; stays RD_LAT cycles total, then -> PRESENT.
REQ-024 PRESENT entry: {Rin,Gin,Bin} register douta once; OKin=1 and all three held stable until exit.
REQ-025 PRESENT: OKout=0 -> stay; OKout=1 -> WRITE, with {Rout,Gout,Bout} captured to wr_data that edge.
REQ-026 WRITE (1 cycle): wr_en=1, wr_addr=idx, OKin=0.
REQ-027 RELEASE: OKin=0; stays while OKout=1; OKout=0 -> READ with idx+1, or DONE if idx=NPIX-1.
REQ-028 DONE (1 cycle): done=1, busy=0 next cycle -> IDLE.
REQ-029 OKout=1 in any state other than PRESENT/RELEASE has no effect.
REQ-030 Minimum per-pixel cost 4+RD_LAT cycles (READ, WAIT, PRESENT, WRITE, RELEASE at 1 cycle each).
REQ-031 idx is AW bits, counts 0..NPIX-1; never wraps; never exceeds NPIX-1.
REQ-032 abort=1 in any non-IDLE state -> IDLE next edge, OKin=0, no wr_en, no done; abort in IDLE ignored.
REQ-033 abort and start same cycle in IDLE: start wins (abort ignored in IDLE).
REQ-034 wr_en asserted exactly once per pixel; exactly NPIX write strobes per completed image, addresses 0..NPIX-1 ascending.
REQ-035 ena=0, wr_en=0 outside READ/WAIT and WRITE respectively.

Reset
REQ-036 reset=0 forces immediately: state IDLE, idx=0, addra=0, ena=0, OKin=0, Rin=Gin=Bin=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
REQ-037 Reset mid-image discards the image; no further writes until a new start after reset release.
REQ-038 First start is honoured on the first rising edge with reset=1.

Verification
REQ-039 NPIX=4, RD_LAT=1, BRAM={0x102030,0x405060,0x708090,0xA0B0C0}, process model OKout=OKin after 1 cycle, inversion -> wr_data 0xEFDFCF,0xBFAF9F,0x8F7F6F,0x5F4F3F at wr_addr 0..3; one done pulse; 6 cycles per pixel.
REQ-040 OKout delayed 5 cycles -> OKin and Rin/Gin/Bin stable 5+ cycles, single wr_en per pixel, outputs identical to REQ-039.
REQ-041 OKout held high 3 cycles after OKin drop -> FSM stays RELEASE 3 cycles; no extra wr_en; next addra only after OKout=0.
REQ-042 abort during PRESENT of pixel 2 -> IDLE next edge, OKin=0, only 2 writes, no done; new start reruns from addra=0.
REQ-043 reset=0 asynchronously mid-WAIT -> all outputs zero before next edge; start ignored while reset=0.
REQ-044 start pulsed while busy -> ignored; RD_LAT=3 run -> addra held 3 cycles per pixel, same data as REQ-039.
